// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encoding and mode constants for the timer controller
package timer_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock into a tick every pre+1 enabled cycles
module timer_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] pre,
    output logic             tick
);
    logic [PRE_W-1:0] cnt_q, cnt_d;
    assign tick = en && (cnt_q == pre);
    // clear wins, hold when disabled, wrap on tick
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    // prescale counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: load/run/pause/expire sequencer for a prescaled down-counter
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic [PRE_W-1:0] cfg_pre,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, load_q, load_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             mode_q, mode_d, tc_q, tc_d, done_q, done_d;
    logic             acc, clr, tick, running;
    assign running   = (state_q == RUN);
    assign cfg_ready = !running;
    assign acc       = cfg_valid && cfg_ready;
    assign count     = count_q;
    assign busy      = running;
    assign tc_pulse  = tc_q;
    assign done      = done_q;
    // stop freezes the prescaler so a coincident tick is lost rather than deferred
    timer_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (running && !stop),
        .pre (pre_q),
        .tick(tick)
    );
    // next state: config is applied before start so a coincident start runs on new values
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        done_d  = done_q;
        tc_d    = 1'b0;
        clr     = 1'b0;
        if (acc) begin
            load_d  = cfg_load;
            pre_d   = cfg_pre;
            mode_d  = cfg_mode;
            count_d = cfg_load;
            done_d  = 1'b0;
            clr     = 1'b1;
            if (state_q == DONE) state_d = IDLE;
        end
        if (!running && start) begin
            state_d = RUN;
            done_d  = 1'b0;
            clr     = 1'b1;
            if (state_q == DONE) count_d = acc ? cfg_load : load_q;
        end
        if (running) begin
            if (stop) state_d = PAUSE;
            else if (tick && count_q != '0) count_d = count_q - 1'b1;
            else if (tick) begin
                tc_d = 1'b1;
                if (mode_q == MODE_RELOAD) count_d = load_q;
                else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end
    // state, counter and shadow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            load_q  <= '0;
            pre_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable down-counting timer controller that sequences a WIDTH-bit counter through load, run, pause and terminal-count phases.
- Configuration is accepted over a valid/ready handshake.
- Tick rate is divided by a programmable prescaler.
- Emits a one-cycle terminal-count pulse.
- Supports one-shot and auto-reload modes.
- Sits between the software-visible control registers and the counter datapath; it is the scheduler for every counter instance in the design.

Parameters:
WIDTH, 4, counter width in bits
PRE_W, 4, prescaler divide-value width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offered this cycle
cfg_ready  output  1  controller can accept configuration
cfg_load  input  WIDTH  reload/start value of the counter
cfg_pre  input  PRE_W  prescale value; counter ticks every cfg_pre+1 clocks
cfg_mode  input  1  0 = one-shot, 1 = auto-reload
start  input  1  begin or resume counting (single-cycle strobe)
stop  input  1  pause counting (single-cycle strobe)
count  output  WIDTH  current counter value
busy  output  1  high while in RUN
tc_pulse  output  1  one-cycle pulse when the counter expires
done  output  1  level, high after a one-shot expiry until cleared

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; count = 0; shadow load/pre/mode registers = 0; prescaler = 0.
  - busy = 0, tc_pulse = 0, done = 0, cfg_ready = 1.
  - Reset asserted mid-RUN aborts immediately; no tc_pulse is produced.
- FSM states: IDLE, RUN, PAUSE, DONE. Encoding comes from the shared package.
- cfg_ready = 1 in IDLE, PAUSE and DONE; 0 in RUN.
- Config accept: cfg_valid & cfg_ready.
  - Latches cfg_load, cfg_pre and cfg_mode into shadow registers.
  - Sets count <= cfg_load and clears the prescaler and done.
  - State is unchanged, except DONE -> IDLE.
  - cfg_valid while in RUN is ignored. It is not queued; the requester holds valid.
- start in IDLE/PAUSE/DONE -> RUN next cycle.
  - Prescaler cleared.
  - DONE clears done.
  - start in DONE reloads count from the shadow load.
  - start in RUN is ignored.
- Simultaneous cfg accept + start: the config applies first, and RUN uses the new values in the same edge.
- Prescaler:
  - Counts 0..pre in RUN.
  - tick = (prescaler == pre); the prescaler wraps to 0 on tick.
  - pre = 0 gives a tick every clock.
- On tick in RUN:
  - count != 0: count <= count - 1.
  - count == 0: tc_pulse = 1 for exactly the following cycle (registered).
    - Auto-reload: count <= shadow load and state stays RUN.
    - One-shot: state -> DONE, count stays 0, done = 1.
- Period: auto-reload period = (load+1)*(pre+1) clocks. load = 0, pre = 0 gives tc_pulse every clock.
- First tick latency: first decrement occurs pre+1 clocks after entering RUN.
- stop in RUN -> PAUSE.
  - count and prescaler hold.
  - stop wins over a coincident tick: no decrement and no tc_pulse.
  - stop outside RUN is ignored.
- start and stop in the same cycle: stop wins in RUN, start wins elsewhere.
- busy = (state == RUN), registered with the state.
- Arithmetic: counting is modulo 2^WIDTH, but underflow never occurs because 0 triggers expiry.

Decomposition:
- Package timer_ctrl_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the mode constants MODE_ONESHOT = 0 and MODE_RELOAD = 1.
- Sub-module timer_prescaler (PRE_W):
  - inputs clk, rst, clr, en, pre;
  - output tick;
  - instantiated once.
- The FSM and counter stay in timer_ctrl.

Test Plan:
- Reset release, no stimulus -> count=0, busy=0, done=0, tc_pulse=0, cfg_ready=1 for 20 cycles.
- cfg load=3, pre=0, mode=one-shot; start -> count 3,2,1,0 on consecutive clocks; tc_pulse one cycle; then done=1, busy=0, count=0.
- cfg load=2, pre=1, mode=reload; start -> tc_pulse every 6 clocks across 5 periods; count sequence 2,2,1,1,0,0 repeats.
- RUN with load=9, pre=0; stop at count=5 -> count holds 5 for 10 cycles, cfg_ready=1; start -> resumes at 4; expiry after 5 more ticks.
- In RUN, cfg_valid with load=7 -> cfg_ready=0, no change; after one-shot expiry the held cfg is accepted, done clears, count=7.
- Assert rst mid-RUN at count=6 -> count=0, state IDLE, busy=0 asynchronously, with no tc_pulse.
